// File: rtl/i2c_pkg.sv
// i2c_pkg: I2C target FSM state encodings and ACK/NAK line levels, shared with the controller side
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, IGNORE
  } state_e;
  localparam logic ACK = 1'b0;
  localparam logic NAK = 1'b1;
endpackage

// File: rtl/i2c_busmon.sv
// i2c_busmon: two-flop synchronizer for SCL/SDA with SCL edge, START and STOP detection
module i2c_busmon (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  always_comb begin
    scl_d = {scl_q[1:0], i_scl};
    sda_d = {sda_q[1:0], i_sda};
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end
  // stage 2 holds the previous synchronized level for edge detection
  assign o_sda      = sda_q[1];
  assign o_scl_rise = scl_q[1] & ~scl_q[2];
  assign o_scl_fall = ~scl_q[1] & scl_q[2];
  assign o_start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign o_stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/lli2cs.sv
// lli2cs: I2C target with byte-wide write/read user interface.
// Define I2CS_STRETCH_EN to stretch SCL while read data is late; otherwise late data sends FFh and flags o_err.
module lli2cs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_wr_stb,
  output logic [7:0] o_wr_data,
  output logic       o_rd_req,
  input  logic       i_rd_stb,
  input  logic [7:0] i_rd_data,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_nak,
  output logic       o_err,
  output logic       o_busy
);
  import i2c_pkg::*;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, wr_data_q, wr_data_d;
  logic sda_q, sda_d, scl_q, scl_d;
  logic wr_stb_q, wr_stb_d, rd_req_q, rd_req_d, start_q, start_d;
  logic stop_q, stop_d, nak_q, nak_d, err_q, err_d;
  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;
  logic busy, addr_hit, began;
  logic [7:0] byte_in;

  i2c_busmon u_busmon (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (sda_s),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (bus_start),
    .o_stop     (bus_stop)
  );

  assign byte_in  = {sr_q[6:0], sda_s};
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) && (|byte_in[7:1]);
  assign busy     = state_q inside {ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK};
  // the byte slot has already started once the falling edge is seen (or SCL is being held)
  assign began    = ~scl_q | scl_fall;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    wr_data_d = wr_data_q;
    sda_d     = sda_q;
    scl_d     = scl_q;
    wr_stb_d  = 1'b0;
    rd_req_d  = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    nak_d     = 1'b0;
    err_d     = 1'b0;
    if (bus_stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      sda_d   = 1'b1;
      scl_d   = 1'b1;
      stop_d  = busy;
    end else if (bus_start) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
      scl_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sr_d    = byte_in;
          cnt_d   = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
          state_d = (cnt_q != 4'd7) ? ADDR : addr_hit ? ADDR_ACK : IGNORE;
          start_d = (cnt_q == 4'd7) && addr_hit;
        end
        ADDR_ACK: if (scl_fall) sda_d = ACK;
          else if (scl_rise) begin
            state_d  = sr_q[0] ? RD_LOAD : WR_BYTE;
            rd_req_d = sr_q[0];
          end
        WR_BYTE: begin
          if (scl_fall) sda_d = 1'b1;
          if (scl_rise) begin
            sr_d      = byte_in;
            cnt_d     = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
            state_d   = (cnt_q == 4'd7) ? WR_ACK : WR_BYTE;
            wr_data_d = (cnt_q == 4'd7) ? byte_in : wr_data_q;
            wr_stb_d  = (cnt_q == 4'd7);
          end
        end
        WR_ACK: if (scl_fall) sda_d = ACK;
          else if (scl_rise) state_d = WR_BYTE;
        RD_LOAD: if (i_rd_stb) begin
          state_d = RD_BYTE;
          scl_d   = 1'b1;
          sda_d   = began ? i_rd_data[7] : sda_q;
          sr_d    = began ? {i_rd_data[6:0], 1'b1} : i_rd_data;
          cnt_d   = began ? 4'd1 : 4'd0;
        end else if (scl_fall) begin
`ifdef I2CS_STRETCH_EN
          sda_d = 1'b1;
          scl_d = 1'b0;
`else
          state_d = RD_BYTE;
          sda_d   = 1'b1;
          sr_d    = '1;
          cnt_d   = 4'd1;
          err_d   = 1'b1;
`endif
        end
        RD_BYTE: if (scl_fall) begin
          sda_d   = (cnt_q == 4'd8) ? 1'b1 : sr_q[7];
          sr_d    = {sr_q[6:0], 1'b1};
          cnt_d   = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
          state_d = (cnt_q == 4'd8) ? RD_ACK : RD_BYTE;
        end
        RD_ACK: if (scl_rise) begin
          state_d  = (sda_s == ACK) ? RD_LOAD : IGNORE;
          rd_req_d = (sda_s == ACK);
          nak_d    = (sda_s == NAK);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      wr_data_q <= '0;
      sda_q     <= 1'b1;
      scl_q     <= 1'b1;
      wr_stb_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      nak_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      wr_data_q <= wr_data_d;
      sda_q     <= sda_d;
      scl_q     <= scl_d;
      wr_stb_q  <= wr_stb_d;
      rd_req_q  <= rd_req_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      nak_q     <= nak_d;
      err_q     <= err_d;
    end
  end

`ifdef I2CS_STRETCH_EN
  assign o_scl = scl_q;
`else
  assign o_scl = 1'b1;
`endif
  assign o_sda     = sda_q;
  assign o_wr_stb  = wr_stb_q;
  assign o_wr_data = wr_data_q;
  assign o_rd_req  = rd_req_q;
  assign o_start   = start_q;
  assign o_stop    = stop_q;
  assign o_nak     = nak_q;
  assign o_err     = err_q;
  assign o_busy    = busy;
endmodule

// File: tb/tb_lli2cs.sv
// tb_lli2cs: scoreboard bench for lli2cs; an open-drain bus controller drives transfers, a monitor checks event pulses
module tb_lli2cs;
  localparam int H = 40;
  localparam int K_START = 0, K_STOP = 1, K_WR = 2, K_RDREQ = 3, K_NAK = 4, K_ERR = 5;
  typedef struct {
    int         k;
    logic [7:0] d;
  } ev_t;
  ev_t exp_q[$];
  logic [7:0] rd_q[$];
  int total = 0, bad = 0;
  int rd_delay = 2, stretch_max = 0;
  logic clk = 1'b0, reset_n = 1'b0;
  logic tb_scl = 1'b1, tb_sda = 1'b1;
  logic watch = 1'b0, sda_low_seen = 1'b0, busy_seen = 1'b0;
  logic o_scl, o_sda, o_wr_stb, o_rd_req, o_start, o_stop, o_nak, o_err, o_busy;
  logic [7:0] o_wr_data, i_rd_data;
  logic i_rd_stb;
  logic scl_line, sda_line;

  assign scl_line = tb_scl & o_scl;
  assign sda_line = tb_sda & o_sda;

  lli2cs dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_scl     (scl_line),
    .i_sda     (sda_line),
    .o_scl     (o_scl),
    .o_sda     (o_sda),
    .o_wr_stb  (o_wr_stb),
    .o_wr_data (o_wr_data),
    .o_rd_req  (o_rd_req),
    .i_rd_stb  (i_rd_stb),
    .i_rd_data (i_rd_data),
    .o_start   (o_start),
    .o_stop    (o_stop),
    .o_nak     (o_nak),
    .o_err     (o_err),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.k = k;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int k, input logic [7:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: got kind %0d data %h, required no event", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.d !== d) begin
        bad++;
        $display("FAIL event: got kind %0d data %h, required kind %0d data %h", k, d, e.k, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (o_start) got_ev(K_START, 8'h00);
    if (o_wr_stb) got_ev(K_WR, o_wr_data);
    if (o_rd_req) got_ev(K_RDREQ, 8'h00);
    if (o_nak) got_ev(K_NAK, 8'h00);
    if (o_err) got_ev(K_ERR, 8'h00);
    if (o_stop) got_ev(K_STOP, 8'h00);
    if (watch && !o_sda) sda_low_seen = 1'b1;
    if (watch && o_busy) busy_seen = 1'b1;
  end

  initial begin
    i_rd_stb  = 1'b0;
    i_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (o_rd_req) begin
        repeat (rd_delay) @(negedge clk);
        i_rd_data = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
        i_rd_stb  = 1'b1;
        @(negedge clk);
        i_rd_stb  = 1'b0;
      end
    end
  end

  task automatic hw();
    repeat (H) @(negedge clk);
  endtask

  task automatic scl_up();
    int n = 0;
    tb_scl = 1'b1;
    @(negedge clk);
    while (!scl_line && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n > stretch_max) stretch_max = n;
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL scl_release: SCL low for %0d cycles, required high", n);
    end
  endtask

  task automatic bus_start();
    repeat (4) @(negedge clk);
    tb_sda = 1'b1; hw();
    scl_up(); hw();
    tb_sda = 1'b0; hw();
    tb_scl = 1'b0;
  endtask

  task automatic bus_stop();
    repeat (4) @(negedge clk);
    tb_sda = 1'b0; hw();
    scl_up(); hw();
    tb_sda = 1'b1; hw();
  endtask

  task automatic bus_bit(input logic b, output logic r);
    repeat (4) @(negedge clk);
    tb_sda = b; hw();
    scl_up(); hw();
    r = sda_line;
    tb_scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic ackb, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      b[i] = r;
    end
    bus_bit(ackb, r);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic a;
    logic [7:0] b;
    logic [3:0] part;
    repeat (5) @(negedge clk);
    check("rst_scl", o_scl, 1);
    check("rst_sda", o_sda, 1);
    check("rst_busy", o_busy, 0);
    check("rst_wr_data", o_wr_data, 8'h00);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    expect_ev(K_START, 0); expect_ev(K_WR, 8'hA5); expect_ev(K_WR, 8'h3C); expect_ev(K_STOP, 0);
    bus_start();
    wr_byte(8'hA0, a); check("wr_addr_ack", a, 0);
    wr_byte(8'hA5, a); check("wr_a5_ack", a, 0);
    wr_byte(8'h3C, a); check("wr_3c_ack", a, 0);
    bus_stop();
    drain("wr_pending");
    check("wr_data_hold", o_wr_data, 8'h3C);

    watch = 1'b1;
    bus_start();
    wr_byte(8'hA2, a); check("nm_addr_ack", a, 1);
    wr_byte(8'h55, a); check("nm_data_ack", a, 1);
    bus_stop();
    repeat (10) @(negedge clk);
    watch = 1'b0;
    check("nm_sda_low", sda_low_seen, 0);
    check("nm_busy", busy_seen, 0);
    drain("nm_pending");

    rd_q.push_back(8'h96); rd_q.push_back(8'h0F);
    expect_ev(K_START, 0); expect_ev(K_RDREQ, 0); expect_ev(K_RDREQ, 0); expect_ev(K_NAK, 0);
    bus_start();
    wr_byte(8'hA1, a); check("rd_addr_ack", a, 0);
    rd_byte(1'b0, b); check("rd_byte0", b, 8'h96);
    rd_byte(1'b1, b); check("rd_byte1", b, 8'h0F);
    bus_stop();
    drain("rd_pending");

    rd_delay = 500;
    stretch_max = 0;
    rd_q.push_back(8'h5A);
    expect_ev(K_START, 0); expect_ev(K_RDREQ, 0);
`ifndef I2CS_STRETCH_EN
    expect_ev(K_ERR, 0);
`endif
    expect_ev(K_NAK, 0);
    bus_start();
    wr_byte(8'hA1, a); check("st_addr_ack", a, 0);
    stretch_max = 0;
    rd_byte(1'b1, b);
`ifdef I2CS_STRETCH_EN
    check("st_byte", b, 8'h5A);
    check("st_held", stretch_max >= 300, 1);
`else
    check("st_byte", b, 8'hFF);
    check("st_held", stretch_max, 0);
`endif
    bus_stop();
    repeat (600) @(negedge clk);
    rd_delay = 2;
    drain("st_pending");

    rd_q.push_back(8'hC3);
    expect_ev(K_START, 0); expect_ev(K_START, 0); expect_ev(K_RDREQ, 0); expect_ev(K_NAK, 0);
    bus_start();
    wr_byte(8'hA0, a); check("rs_addr_ack", a, 0);
    part = 4'b1011;
    for (int i = 3; i >= 0; i--) bus_bit(part[i], a);
    bus_start();
    wr_byte(8'hA1, a); check("rs_raddr_ack", a, 0);
    rd_byte(1'b1, b); check("rs_byte", b, 8'hC3);
    bus_stop();
    drain("rs_pending");

    rd_q.push_back(8'h00);
    expect_ev(K_START, 0); expect_ev(K_RDREQ, 0);
    bus_start();
    wr_byte(8'hA1, a); check("rr_addr_ack", a, 0);
    repeat (3) bus_bit(1'b1, a);
    repeat (6) @(negedge clk);
    check("rr_sda_driven", o_sda, 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rr_sda", o_sda, 1);
    check("rr_busy", o_busy, 0);
    tb_sda = 1'b1; hw();
    tb_scl = 1'b1; hw();
    expect_ev(K_START, 0); expect_ev(K_WR, 8'h11); expect_ev(K_STOP, 0);
    bus_start();
    wr_byte(8'hA0, a); check("rr_addr2_ack", a, 0);
    wr_byte(8'h11, a); check("rr_data_ack", a, 0);
    bus_stop();
    drain("rr_pending");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end
endmodule
